// File: rtl/inv_clark_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inv_clark_pkg
// Description : Shared helpers for the inverse Clarke pipeline: the
//               sqrt(3)/2 coefficient builder and the output clip.
// Revision    : 1.0 - initial release
// ============================================================================
package inv_clark_pkg;

    // round(sqrt(3)/2 * 2^kf) == round(sqrt(3 * 4^(kf-1))), integer-only
    function automatic longint k2_calc(input int kf);
        longint n;
        longint s;
        longint t;
        n = 64'sd3 << (2 * (kf - 1));
        s = 64'sd0;
        for (int i = 30; i >= 0; i--) begin
            t = s | (64'sd1 << i);
            if (t * t <= n) s = t;
        end
        if (n - s * s > s) s = s + 64'sd1;
        return s;
    endfunction

    // {flag, value}: value limited to the signed w-bit range
    function automatic logic [64:0] clip_fn(input longint v, input int w);
        longint hi;
        longint lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return {1'b1, hi};
        if (v < lo) return {1'b1, lo};
        return {1'b0, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_clip.sv
`default_nettype none
// ============================================================================
// Module      : sat_clip
// Description : Combinational clip of a W+2 bit signed value to W bits.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_clip
    import inv_clark_pkg::*;
#(
    parameter int W = 16
) (
    input  logic signed [W+1:0] din,
    output logic signed [W-1:0] dout,
    output logic                clip
);

    logic [64:0] w_res;

    assign w_res = clip_fn(longint'(din), W);
    assign dout  = W'(w_res);
    assign clip  = w_res[64];

endmodule
`default_nettype wire

// File: rtl/inv_clark_pipe.sv
`default_nettype none
// ============================================================================
// Module      : inv_clark_pipe
// Description : Three-stage inverse Clarke transform (alpha/beta/gamma to
//               a/b/c) with valid/ready flow control and optional saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module inv_clark_pipe
    import inv_clark_pkg::*;
#(
    parameter int W      = 16,
    parameter int KF     = 15,
    parameter int SAT_EN = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic signed [W-1:0] alpha,
    input  logic signed [W-1:0] beta,
    input  logic signed [W-1:0] gamma,
    input  logic                in_valid,
    output logic                in_ready,
    output logic signed [W-1:0] a,
    output logic signed [W-1:0] b,
    output logic signed [W-1:0] c,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2:0]          out_sat,
    output logic                sat_sticky
);

    localparam int                     c_pw  = W + KF + 2;
    localparam logic signed [KF+1:0]   c_k2  = (KF+2)'(k2_calc(KF));
    localparam logic signed [c_pw-1:0] c_rnd = c_pw'(64'sd1 <<< (KF - 1));

    logic                   w_en;
    logic signed [W+1:0]    w_h;
    logic signed [c_pw-1:0] w_p;
    logic signed [c_pw-1:0] w_kr;
    logic signed [W+1:0]    w_k;
    logic signed [W-1:0]    w_a;
    logic signed [W-1:0]    w_b;
    logic signed [W-1:0]    w_c;
    logic [2:0]             w_sat;

    logic                   r1_v;
    logic signed [W+1:0]    r1_h;
    logic signed [c_pw-1:0] r1_p;
    logic signed [W+1:0]    r1_al;
    logic signed [W+1:0]    r1_ga;
    logic                   r2_v;
    logic signed [W+1:0]    r2_a;
    logic signed [W+1:0]    r2_b;
    logic signed [W+1:0]    r2_c;

    // The whole pipe freezes only when the output register holds an unread sample
    assign w_en     = out_ready | ~out_valid;
    assign in_ready = w_en;

    assign w_h  = (W+2)'(alpha >>> 1);
    assign w_p  = c_pw'(beta) * c_pw'(c_k2);
    assign w_kr = (r1_p + c_rnd) >>> KF;
    assign w_k  = (W+2)'(w_kr);

    generate
        if (SAT_EN != 0) begin : g_sat
            sat_clip #(.W(W)) u_clip_a (.din(r2_a), .dout(w_a), .clip(w_sat[0]));
            sat_clip #(.W(W)) u_clip_b (.din(r2_b), .dout(w_b), .clip(w_sat[1]));
            sat_clip #(.W(W)) u_clip_c (.din(r2_c), .dout(w_c), .clip(w_sat[2]));
        end else begin : g_wrap
            assign w_a   = W'(r2_a);
            assign w_b   = W'(r2_b);
            assign w_c   = W'(r2_c);
            assign w_sat = 3'b000;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r1_v       <= 1'b0;
            r1_h       <= '0;
            r1_p       <= '0;
            r1_al      <= '0;
            r1_ga      <= '0;
            r2_v       <= 1'b0;
            r2_a       <= '0;
            r2_b       <= '0;
            r2_c       <= '0;
            out_valid  <= 1'b0;
            a          <= '0;
            b          <= '0;
            c          <= '0;
            out_sat    <= 3'b000;
            sat_sticky <= 1'b0;
        end else begin
            if (w_en) begin
                r1_v      <= in_valid;
                r1_h      <= w_h;
                r1_p      <= w_p;
                r1_al     <= (W+2)'(alpha);
                r1_ga     <= (W+2)'(gamma);
                r2_v      <= r1_v;
                r2_a      <= r1_al + r1_ga;
                r2_b      <= r1_ga - r1_h + w_k;
                r2_c      <= r1_ga - r1_h - w_k;
                out_valid <= r2_v;
                a         <= w_a;
                b         <= w_b;
                c         <= w_c;
                out_sat   <= w_sat & {3{r2_v}};
            end
            if (out_valid && out_ready && (out_sat != 3'b000)) begin
                sat_sticky <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inv_clark_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_inv_clark_pipe
// Description : Directed plus random bench for inv_clark_pipe against an
//               integer reference of the transform.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_inv_clark_pipe;

    localparam int W = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic signed [W-1:0] alpha = '0;
    logic signed [W-1:0] beta = '0;
    logic signed [W-1:0] gamma = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic signed [W-1:0] c;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [2:0]          out_sat;
    logic                sat_sticky;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inv_clark_pipe #(.W(W), .KF(15), .SAT_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .alpha(alpha), .beta(beta), .gamma(gamma),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sat(out_sat), .sat_sticky(sat_sticky)
    );

    typedef struct {
        int       a;
        int       b;
        int       c;
        bit [2:0] sat;
        int       acc;
    } exp_t;

    exp_t                q[$];
    int                  cyc = 0;
    bit                  lat_chk = 1'b0;
    bit                  sticky_exp = 1'b0;
    bit                  stall_prev = 1'b0;
    logic signed [W-1:0] pa, pb, pc;
    logic [2:0]          psat;

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, expv);
        end
    endtask

    function automatic int fdiv(input int n, input int d);
        int qv;
        qv = n / d;
        if ((n % d != 0) && (n < 0)) qv = qv - 1;
        return qv;
    endfunction

    function automatic int clipv(input int v, output bit s);
        s = 1'b1;
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        s = 1'b0;
        return v;
    endfunction

    function automatic exp_t model(input int al, input int be, input int ga, input int acc);
        exp_t e;
        int   h, k;
        bit   sa, sb, sc;
        h     = fdiv(al, 2);
        k     = fdiv(be * 28378 + 16384, 32768);
        e.a   = clipv(al + ga, sa);
        e.b   = clipv(-h + k + ga, sb);
        e.c   = clipv(-h - k + ga, sc);
        e.sat = {sc, sb, sa};
        e.acc = acc;
        return e;
    endfunction

    // One clock: drive at the falling edge, observe 1ns later, score the
    // transfers that the following rising edge will perform.
    task automatic cycle(input bit rst, input bit iv, input int al, input int be,
                         input int ga, input bit ordy);
        exp_t e;
        @(negedge clk);
        rst_n     = rst;
        in_valid  = iv;
        alpha     = W'(al);
        beta      = W'(be);
        gamma     = W'(ga);
        out_ready = ordy;
        #1;
        cyc++;
        if (!rst) begin
            q.delete();
            sticky_exp = 1'b0;
            stall_prev = 1'b0;
            return;
        end
        chk("sat_sticky", sat_sticky, sticky_exp);
        if (stall_prev) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_a", a, pa);
            chk("hold_b", b, pb);
            chk("hold_c", c, pc);
            chk("hold_sat", out_sat, psat);
        end
        if (out_valid === 1'b1 && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", out_valid, 0);
            end else begin
                e = q.pop_front();
                chk("out_a", a, e.a);
                chk("out_b", b, e.b);
                chk("out_c", c, e.c);
                chk("out_sat", out_sat, e.sat);
                if (lat_chk) chk("latency", cyc - e.acc, 3);
                if (e.sat != 3'b000) sticky_exp = 1'b1;
            end
        end
        if (in_valid && in_ready === 1'b1) q.push_back(model(al, be, ga, cyc));
        stall_prev = (out_valid === 1'b1) && !out_ready;
        pa   = a;
        pb   = b;
        pc   = c;
        psat = out_sat;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 0, 0, 0, 1'b1);
    endtask

    task automatic send(input int al, input int be, input int ga);
        cycle(1'b1, 1'b1, al, be, ga, 1'b1);
    endtask

    function automatic int rnd_val();
        logic signed [15:0] v;
        case ($urandom_range(0, 9))
            0:       return -32768;
            1:       return 32767;
            2:       return 0;
            default: begin
                v = 16'($urandom);
                return int'(v);
            end
        endcase
    endfunction

    initial begin
        int idx;
        int sa[8], sb[8], sg[8];

        cycle(1'b0, 1'b0, 0, 0, 0, 1'b1);
        cycle(1'b0, 1'b0, 0, 0, 0, 1'b1);
        cycle(1'b1, 1'b0, 0, 0, 0, 1'b1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_a", a, 0);
        chk("rst_b", b, 0);
        chk("rst_c", c, 0);
        chk("rst_out_sat", out_sat, 0);

        lat_chk = 1'b1;
        send(1000, 0, 0);
        idle(4);
        send(0, 1000, 0);
        idle(4);
        send(32767, 0, 32767);
        idle(4);
        chk("sticky_after_clip", sat_sticky, 1);
        send(-32768, -32768, -32768);
        send(-32768, 32767, -32768);
        send(32767, -32768, 32767);
        send(-32768, 0, 32767);
        for (int i = 0; i < 6; i++) send(rnd_val(), rnd_val(), rnd_val());
        idle(5);

        // Eight-sample stream with the consumer stalled for cycles 4..8
        lat_chk = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sa[i] = rnd_val();
            sb[i] = rnd_val();
            sg[i] = rnd_val();
        end
        idx = 0;
        for (int t = 1; t <= 20; t++) begin
            if (idx < 8) cycle(1'b1, 1'b1, sa[idx], sb[idx], sg[idx], !(t >= 4 && t <= 8));
            else         cycle(1'b1, 1'b0, 0, 0, 0, !(t >= 4 && t <= 8));
            if (t >= 4 && t <= 8) chk("in_ready_stall", in_ready, 0);
            if (idx < 8 && in_ready === 1'b1) idx++;
        end
        chk("stream_all_sent", idx, 8);
        chk("stream_drained", q.size(), 0);

        // Reset with two samples in flight
        lat_chk = 1'b1;
        send(1234, 567, -89);
        send(-4321, 765, 98);
        cycle(1'b0, 1'b0, 0, 0, 0, 1'b1);
        send(2000, -2000, 300);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_sticky", sat_sticky, 0);
        idle(6);
        chk("post_rst_drained", q.size(), 0);

        // Random valid/ready traffic
        lat_chk = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            cycle(1'b1, ($urandom_range(0, 3) != 0), rnd_val(), rnd_val(), rnd_val(),
                  ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
        chk("final_drain", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
